// File: rtl/differentiator.sv
// Comb (differentiator) stage: y[n] = x[n] - x[n-M] over accepted samples.
// The arithmetic is modular two's-complement, so wrap-around in an upstream integrator cancels out.
module differentiator #(
    parameter int I_BW = 8,
    parameter int O_BW = 8,
    parameter int M    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic signed [I_BW-1:0] data_i,
    input  logic                   valid_i,
    output logic signed [O_BW-1:0] data_o,
    output logic                   valid_o
);
    localparam int DW = I_BW + 1;
    localparam int EW = (O_BW > DW) ? O_BW : DW;

    logic                   w_acc;
    logic signed [I_BW-1:0] w_old;
    logic signed [DW-1:0]   w_diff;
    logic signed [O_BW-1:0] w_out;
    logic signed [O_BW-1:0] r_data;
    logic                   r_valid;

    // Sign-extend to the wider of the two widths, then keep the low O_BW bits.
    // This covers both modular truncation and sign extension.
    function automatic logic signed [O_BW-1:0] fit_out(input logic signed [DW-1:0] d);
        logic signed [EW-1:0] ext;
        ext = EW'(d);
        return ext[O_BW-1:0];
    endfunction

    assign w_acc  = en_i && valid_i;
    assign w_diff = DW'(data_i) - DW'(w_old);
    assign w_out  = fit_out(w_diff);

    generate
        if (M == 1) begin : g_single
            logic signed [I_BW-1:0] r_hist;

            assign w_old = r_hist;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_hist <= '0;
                end else if (w_acc) begin
                    r_hist <= data_i;
                end
            end
        end else begin : g_ring
            localparam int PW = $clog2(M);

            logic signed [I_BW-1:0] r_hist [M];
            logic [PW-1:0]          r_wp;

            assign w_old = r_hist[r_wp];

            // The pointer wraps by compare so that delays which are not a power of two still cycle 0..M-1.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int k = 0; k < M; k++) begin
                        r_hist[k] <= '0;
                    end
                    r_wp <= '0;
                end else if (w_acc) begin
                    r_hist[r_wp] <= data_i;
                    r_wp         <= (r_wp == PW'(M - 1)) ? '0 : r_wp + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_acc;
            if (w_acc) begin
                r_data <= w_out;
            end
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;

endmodule

// File: tb/tb_differentiator.sv
// Directed bench for the differentiator: several parameterizations share one stimulus bus.
// Each scenario task resets the instances and checks its outputs against hand-computed values.
module tb_differentiator;
    logic              clk;
    logic              rst;
    logic              en;
    logic              vld;
    logic signed [7:0] din;

    logic signed [7:0]  d0_o;   logic d0_v;   // I8 O8  M2
    logic signed [8:0]  d9_o;   logic d9_v;   // I8 O9  M2
    logic signed [11:0] d12_o;  logic d12_v;  // I8 O12 M2
    logic signed [7:0]  m3_o;   logic m3_v;   // I8 O8  M3
    logic signed [4:0]  m1_o;   logic m1_v;   // I8 O5  M1

    int checks   = 0;
    int failures = 0;

    differentiator #(.I_BW(8), .O_BW(8), .M(2)) u_d0 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .data_i(din), .valid_i(vld),
        .data_o(d0_o), .valid_o(d0_v));
    differentiator #(.I_BW(8), .O_BW(9), .M(2)) u_d9 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .data_i(din), .valid_i(vld),
        .data_o(d9_o), .valid_o(d9_v));
    differentiator #(.I_BW(8), .O_BW(12), .M(2)) u_d12 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .data_i(din), .valid_i(vld),
        .data_o(d12_o), .valid_o(d12_v));
    differentiator #(.I_BW(8), .O_BW(8), .M(3)) u_m3 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .data_i(din), .valid_i(vld),
        .data_o(m3_o), .valid_o(m3_v));
    differentiator #(.I_BW(8), .O_BW(5), .M(1)) u_m1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .data_i(din), .valid_i(vld),
        .data_o(m1_o), .valid_o(m1_v));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs on the falling edge, then look at outputs 1 time unit after the rising edge.
    task automatic step(input logic r, input logic e, input logic v, input logic signed [7:0] d);
        @(negedge clk);
        rst = r; en = e; vld = v; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b0, 8'sd0);
        step(1'b0, 1'b1, 1'b0, 8'sd0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 8'sd55);
        checks++;
        if (d0_o !== 8'sd0 || d0_v !== 1'b0 || d9_o !== 9'sd0 || d12_o !== 12'sd0 ||
            m3_o !== 8'sd0 || m1_o !== 5'sd0 || d9_v !== 1'b0 || d12_v !== 1'b0 ||
            m3_v !== 1'b0 || m1_v !== 1'b0) begin
            failures++;
            $display("FAIL reset: d0=%0d/%b d9=%0d d12=%0d m3=%0d m1=%0d required all 0 and valid 0",
                     d0_o, d0_v, d9_o, d12_o, m3_o, m1_o);
        end
    endtask

    task automatic test_basic();
        logic signed [7:0] xin [5] = '{8'sd10, 8'sd20, 8'sd35, 8'sd35, 8'sd0};
        logic signed [7:0] exp [5] = '{8'sd10, 8'sd20, 8'sd25, 8'sd15, -8'sd35};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, xin[i]);
            checks++;
            if (d0_o !== exp[i] || d0_v !== 1'b1) begin
                failures++;
                $display("FAIL basic[%0d]: got %0d valid %b, required %0d valid 1", i, d0_o, d0_v, exp[i]);
            end
        end
        step(1'b0, 1'b1, 1'b0, 8'sd0);
        checks++;
        if (d0_v !== 1'b0 || d0_o !== -8'sd35) begin
            failures++;
            $display("FAIL basic_idle: got %0d valid %b, required -35 valid 0", d0_o, d0_v);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b0, 1'b1, 1'b1, 8'sd127);
        checks++;
        if (d0_o !== 8'sh7F || d9_o !== 9'sh07F || d12_o !== 12'sh07F) begin
            failures++;
            $display("FAIL wrap_first: got %h %h %h, required 7f 07f 07f", d0_o, d9_o, d12_o);
        end
        step(1'b0, 1'b1, 1'b1, 8'sd127);
        step(1'b0, 1'b1, 1'b1, -8'sd128);
        checks++;
        if (d0_o !== 8'sh01 || d0_v !== 1'b1) begin
            failures++;
            $display("FAIL wrap_o8: got %h valid %b, required 01 valid 1", d0_o, d0_v);
        end
        checks++;
        if (d9_o !== 9'sh101 || d9_v !== 1'b1) begin
            failures++;
            $display("FAIL wrap_o9: got %h valid %b, required 101 valid 1", d9_o, d9_v);
        end
        checks++;
        if (d12_o !== 12'shF01 || d12_v !== 1'b1) begin
            failures++;
            $display("FAIL wrap_o12: got %h valid %b, required f01 valid 1", d12_o, d12_v);
        end
    endtask

    task automatic test_m3();
        logic signed [7:0] exp [7] = '{8'sd1, 8'sd2, 8'sd3, 8'sd3, 8'sd3, 8'sd3, 8'sd3};
        logic signed [7:0] x;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            x = 8'(i + 1);
            step(1'b0, 1'b1, 1'b1, x);
            checks++;
            if (m3_o !== exp[i] || m3_v !== 1'b1) begin
                failures++;
                $display("FAIL m3[%0d]: got %0d valid %b, required %0d valid 1", i, m3_o, m3_v, exp[i]);
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        step(1'b0, 1'b1, 1'b1, 8'sd5);
        checks++;
        if (d0_o !== 8'sd5 || d0_v !== 1'b1) begin
            failures++;
            $display("FAIL gap_first: got %0d valid %b, required 5 valid 1", d0_o, d0_v);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'sd77);
            checks++;
            if (d0_o !== 8'sd5 || d0_v !== 1'b0) begin
                failures++;
                $display("FAIL gap_idle[%0d]: got %0d valid %b, required 5 valid 0", i, d0_o, d0_v);
            end
        end
        step(1'b0, 1'b1, 1'b1, 8'sd9);
        checks++;
        if (d0_o !== 8'sd9 || d0_v !== 1'b1) begin
            failures++;
            $display("FAIL gap_second: got %0d valid %b, required 9 valid 1", d0_o, d0_v);
        end
        step(1'b0, 1'b0, 1'b1, 8'sd100);
        checks++;
        if (d0_o !== 8'sd9 || d0_v !== 1'b0) begin
            failures++;
            $display("FAIL gap_disabled: got %0d valid %b, required 9 valid 0", d0_o, d0_v);
        end
        step(1'b0, 1'b1, 1'b1, 8'sd12);
        checks++;
        if (d0_o !== 8'sd7 || d0_v !== 1'b1) begin
            failures++;
            $display("FAIL gap_third: got %0d valid %b, required 7 valid 1", d0_o, d0_v);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(1'b0, 1'b1, 1'b1, 8'sd50);
        step(1'b0, 1'b1, 1'b1, 8'sd60);
        checks++;
        if (d0_o !== 8'sd60 || d0_v !== 1'b1) begin
            failures++;
            $display("FAIL mrst_pre: got %0d valid %b, required 60 valid 1", d0_o, d0_v);
        end
        step(1'b1, 1'b1, 1'b1, 8'sd70);
        checks++;
        if (d0_o !== 8'sd0 || d0_v !== 1'b0) begin
            failures++;
            $display("FAIL mrst_edge: got %0d valid %b, required 0 valid 0", d0_o, d0_v);
        end
        step(1'b0, 1'b1, 1'b1, 8'sd80);
        checks++;
        if (d0_o !== 8'sd80 || d0_v !== 1'b1) begin
            failures++;
            $display("FAIL mrst_80: got %0d valid %b, required 80 valid 1", d0_o, d0_v);
        end
        step(1'b0, 1'b1, 1'b1, 8'sd90);
        checks++;
        if (d0_o !== 8'sd90 || d0_v !== 1'b1) begin
            failures++;
            $display("FAIL mrst_90: got %0d valid %b, required 90 valid 1", d0_o, d0_v);
        end
    endtask

    // An 8-bit integrator fed a constant 3 wraps repeatedly; an M=1 comb with 5-bit output must recover 3.
    task automatic test_roundtrip();
        logic [7:0] integ;
        int         bad;
        integ = 8'd0;
        bad   = 0;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            integ = integ + 8'd3;
            step(1'b0, 1'b1, 1'b1, signed'(integ));
            checks++;
            if (m1_o !== 5'sd3 || m1_v !== 1'b1) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL roundtrip[%0d]: got %0d valid %b (integ=%0d), required 3 valid 1",
                             i, m1_o, m1_v, integ);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; vld = 1'b0; din = 8'sd0;
        test_reset();
        test_basic();
        test_wrap();
        test_m3();
        test_gaps();
        test_mid_reset();
        test_roundtrip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/differentiator.md
Name: differentiator

Overview:
Parameterized comb (differentiator) stage. It computes y[n] = x[n] − x[n−M] over the stream of valid samples and is the inverse of the integrator block. It takes the wide integrator-chain output, typically after a decimator, and closes a CIC decimation path. The arithmetic is modular two's-complement so that integrator wrap-around cancels.

Parameters:
I_BW, 8, input sample width (signed two's complement)
O_BW, 8, output sample width (signed two's complement)
M, 2, differential delay in valid samples; legal range 1..16, any value (not restricted to powers of two)

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  synchronous, active-high reset
en_i  input  1  block enable; when low, inputs are ignored and state is frozen
data_i  input  I_BW  signed input sample
valid_i  input  1  data_i qualifier; sample accepted when en_i && valid_i
data_o  output  O_BW  signed difference sample
valid_o  output  1  one-cycle pulse per accepted input

Behaviour:
- Reset is synchronous, active-high, and dominates all other inputs. On rst_i=1 at a clock edge:
  - data_o=0, valid_o=0
  - all M history entries = 0
  - write pointer = 0
- Reset mid-stream discards all history. The first post-reset sample is differenced against zero.
- History storage: circular buffer of M entries, each I_BW wide, with write pointer wp.
  - wp increments on each accepted sample.
  - wp wraps from M−1 to 0 by compare, not by bit truncation; M=3 must cycle 0,1,2,0.
  - For M=1 the buffer degenerates to a single register and wp stays 0.
- Accept condition: acc = en_i && valid_i.
- On acc at an edge:
  - old = buf[wp]; this is x[n−M].
  - diff = sext(data_i, I_BW+1) − sext(old, I_BW+1), computed at I_BW+1 bits.
  - data_o ← if O_BW ≤ I_BW+1: diff[O_BW−1:0] (modular truncation, no saturation); otherwise sign-extend diff to O_BW.
  - buf[wp] ← data_i; wp ← wrap(wp+1); valid_o ← 1.
- Latency: exactly 1 clock from the accepting edge to data_o/valid_o. Throughput is one sample per clock; back-to-back valid_i is supported.
- No acc (valid_i=0 or en_i=0): valid_o ← 0, data_o holds its last value, buffer and wp are unchanged.
- en_i=0 with valid_i=1: the sample is dropped. It is not stored and produces no output, so history is exactly as before.
- Warm-up: the first M outputs after reset equal the sign-extended or truncated inputs, because they are differenced against zero. valid_o is not suppressed during warm-up.
- There is no backpressure. Downstream must accept every valid_o pulse.
- There is no combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Basic comb, defaults (I_BW=8, O_BW=8, M=2). After reset, back-to-back inputs 10, 20, 35, 35, 0 → data_o 10, 20, 25, 15, −35. Each valid_o pulse occurs 1 cycle after its input.
2. Modular wrap (M=2): feed 127, 127, −128 → third output = 1, i.e. −255 truncated to 8 bits = 0x01. Repeat with O_BW=9 → third output = −255 (0x101). Repeat with O_BW=12 → −255 sign-extended (0xF01).
3. Non-power-of-two delay (M=3): inputs 1, 2, 3, 4, 5, 6, 7 → outputs 1, 2, 3, 3, 3, 3, 3. Confirms wp cycles 0,1,2,0.
4. Enable/valid gaps (M=2):
   - inputs 5, (valid_i=0 for 3 cycles), 9, (en_i=0 with valid_i=1 and data 100), 12 → outputs 5, 9, 7.
   - valid_o stays low during both gaps; data_o holds 5 then 9; the dropped 100 never appears in history.
5. Reset mid-operation (M=2): inputs 50, 60, then rst_i=1 for 1 cycle alongside valid_i=1 with data 70, then 80, 90 → outputs 50, 60, then nothing for the reset cycle.
   - data_o=0 and valid_o=0 after the reset edge.
   - Subsequent outputs are 80, 90, showing the history was zeroed and the 70 was discarded.
6. Integrator round-trip (M=1): drive the integrator (I_BW=5, O_BW=8) with a constant 3 for 200 samples, then feed its output into this block (I_BW=8, O_BW=5). After the 1-sample warm-up every output = 3, including across the integrator's 8-bit wrap points.
